battle_engine: RTL and testbench

Turn-based battle controller directly upstream of `game_state`. While `game_state` reports `is_battle`, this block runs one battle: it tracks HP for the player's three-member team and one enemy, and takes move selection from the keyboard. It applies damage, switches to the next player Pokémon when one faints, and produces the `end_battle`, `result`, `my_cur` and `enemy_cur_id` signals that `game_state` consumes. HP and menu outputs also feed the battle HUD drawing logic.

---
 rtl/battle_engine.sv | 172 +++++++++++++++++
 tb/tb_battle_engine.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/battle_engine.sv
// Turn-based battle controller: player team of three against one enemy,
// keyboard-driven move menu, LFSR-based hit/damage variation.
module battle_engine #(
  parameter int         ENEMY_DELAY = 25_000_000,
  parameter logic [7:0] BASE_HP     = 8'd100
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            is_battle,
  input  logic [7:0]      keycode,
  input  logic [2:0][2:0] my_team,
  input  logic [2:0]      cur_battle,
  output logic            end_battle,
  output logic            result,
  output logic [1:0]      my_cur,
  output logic [2:0]      enemy_cur_id,
  output logic [7:0]      my_hp,
  output logic [7:0]      enemy_hp,
  output logic [1:0]      menu_sel,
  output logic            player_turn
);

  // state    | meaning
  // IDLE     | waiting for a rising edge of is_battle
  // INIT     | load HP, enemy id and menu for a new battle
  // MENU     | player chooses a move with W/S, confirms with ENTER
  // P_ATTACK | apply the chosen move
  // E_WAIT   | pause before the enemy strikes
  // E_ATTACK | enemy damages the active player Pokemon
  // SWITCH   | active Pokemon fainted: bring in the next or lose
  // DONE     | end_battle pulse, back to IDLE
  typedef enum logic [2:0] {
    IDLE, INIT, MENU, P_ATTACK, E_WAIT, E_ATTACK, SWITCH, DONE
  } state_t;

  localparam int         CW        = (ENEMY_DELAY > 1) ? $clog2(ENEMY_DELAY) : 1;
  localparam logic [CW-1:0] DELAY_LOAD = CW'(ENEMY_DELAY - 1);
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_ENTER = 8'h28;

  state_t          state;
  logic [7:0]      lfsr;
  logic [7:0]      prev_key;
  logic            prev_battle;
  logic [2:0][7:0] hp;
  logic [CW-1:0]   delay_cnt;

  logic       key_press;
  logic [7:0] atk_dmg;
  logic [7:0] foe_dmg;
  logic [7:0] enemy_next;
  logic [7:0] hp_healed;
  logic [7:0] hp_hit;
  logic       unused_team;

  // Team ids only travel to game_state through my_cur.
  assign unused_team = ^my_team;

  assign key_press = (keycode != 8'd0) && (keycode != prev_key);
  assign my_hp     = hp[my_cur];

  always_comb begin
    atk_dmg = 8'd0;
    case (menu_sel)
      2'd0:    atk_dmg = 8'd20;
      2'd1:    atk_dmg = 8'd30;
      2'd2:    atk_dmg = (lfsr[1:0] != 2'd0) ? 8'd40 : 8'd0;
      default: atk_dmg = 8'd0;
    endcase
    foe_dmg    = 8'd5 + {4'd0, lfsr[3:0]};
    enemy_next = (enemy_hp > atk_dmg) ? enemy_hp - atk_dmg : 8'd0;
    hp_healed  = (my_hp > BASE_HP - 8'd25) ? BASE_HP : my_hp + 8'd25;
    hp_hit     = (my_hp > foe_dmg) ? my_hp - foe_dmg : 8'd0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      lfsr         <= 8'hA5;
      prev_key     <= 8'd0;
      // Held high so a battle in progress across reset needs a fresh rise.
      prev_battle  <= 1'b1;
      hp           <= '0;
      delay_cnt    <= '0;
      end_battle   <= 1'b0;
      result       <= 1'b0;
      my_cur       <= 2'd0;
      enemy_cur_id <= 3'd0;
      enemy_hp     <= 8'd0;
      menu_sel     <= 2'd0;
      player_turn  <= 1'b0;
    end else begin
      lfsr        <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      prev_key    <= keycode;
      prev_battle <= is_battle;
      end_battle  <= 1'b0;
      player_turn <= 1'b0;
      if (!is_battle && state != IDLE && state != DONE) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (is_battle && !prev_battle) state <= INIT;
          INIT: begin
            hp           <= {3{BASE_HP}};
            my_cur       <= 2'd0;
            menu_sel     <= 2'd0;
            result       <= 1'b0;
            enemy_hp     <= BASE_HP + {1'b0, cur_battle, 4'b0} + {3'b0, cur_battle, 2'b0};
            enemy_cur_id <= cur_battle + 3'd4;
            state        <= MENU;
            player_turn  <= 1'b1;
          end
          MENU: begin
            player_turn <= 1'b1;
            if (key_press) begin
              case (keycode)
                KEY_W: menu_sel <= menu_sel - 2'd1;
                KEY_S: menu_sel <= menu_sel + 2'd1;
                KEY_ENTER: begin
                  state       <= P_ATTACK;
                  player_turn <= 1'b0;
                end
                default: ;
              endcase
            end
          end
          P_ATTACK: begin
            if (menu_sel == 2'd3) hp[my_cur] <= hp_healed;
            enemy_hp <= enemy_next;
            if (enemy_next == 8'd0) begin
              result     <= 1'b1;
              end_battle <= 1'b1;
              state      <= DONE;
            end else begin
              delay_cnt <= DELAY_LOAD;
              state     <= E_WAIT;
            end
          end
          E_WAIT: begin
            if (delay_cnt == '0) state <= E_ATTACK;
            else delay_cnt <= delay_cnt - 1'b1;
          end
          E_ATTACK: begin
            hp[my_cur] <= hp_hit;
            if (hp_hit == 8'd0) begin
              state <= SWITCH;
            end else begin
              state       <= MENU;
              player_turn <= 1'b1;
            end
          end
          SWITCH: begin
            if (my_cur == 2'd2) begin
              result     <= 1'b0;
              end_battle <= 1'b1;
              state      <= DONE;
            end else begin
              my_cur      <= my_cur + 2'd1;
              menu_sel    <= 2'd0;
              state       <= MENU;
              player_turn <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_battle_engine.sv
// Self-checking bench for battle_engine: scenario tasks plus randomized
// battles checked against a turn-level model of the battle rules.
module tb_battle_engine;
  localparam int         D   = 4;
  localparam int         BHP = 100;
  localparam logic [7:0] KW  = 8'h1A;
  localparam logic [7:0] KS  = 8'h16;
  localparam logic [7:0] KE  = 8'h28;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic            is_battle = 1'b0;
  logic [7:0]      keycode = 8'd0;
  logic [2:0][2:0] my_team = {3'd3, 3'd2, 3'd1};
  logic [2:0]      cur_battle = 3'd0;
  logic            end_battle, result, player_turn;
  logic [1:0]      my_cur, menu_sel;
  logic [2:0]      enemy_cur_id;
  logic [7:0]      my_hp, enemy_hp;

  battle_engine #(.ENEMY_DELAY(D), .BASE_HP(8'd100)) dut (
    .Clk(Clk), .Reset(Reset), .is_battle(is_battle), .keycode(keycode),
    .my_team(my_team), .cur_battle(cur_battle), .end_battle(end_battle),
    .result(result), .my_cur(my_cur), .enemy_cur_id(enemy_cur_id),
    .my_hp(my_hp), .enemy_hp(enemy_hp), .menu_sel(menu_sel),
    .player_turn(player_turn)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // Random source of the battle rules: x^8+x^6+x^5+x^4+1, one step per cycle.
  function automatic logic [7:0] lstep(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  logic [7:0] m_lfsr;
  always @(posedge Clk) m_lfsr <= Reset ? 8'hA5 : lstep(m_lfsr);

  int e_enemy;
  int e_hp[3];
  int e_cur;
  int e_sel;
  bit e_done;
  bit e_won;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k;
    tick();
    keycode = 8'd0;
    tick();
  endtask

  task automatic start_battle(input int cb);
    is_battle = 1'b0;
    tick();
    tick();
    cur_battle = 3'(cb);
    is_battle = 1'b1;
    tick();
    tick();
    e_enemy = BHP + 20 * cb;
    for (int i = 0; i < 3; i++) e_hp[i] = BHP;
    e_cur = 0;
    e_sel = 0;
    e_done = 0;
    e_won = 0;
    checks++;
    if (enemy_hp !== 8'(e_enemy)) begin
      failures++;
      $display("FAIL start_enemy_hp got=%0d exp=%0d", enemy_hp, e_enemy);
    end
    checks++;
    if (enemy_cur_id !== 3'((cb + 4) % 8)) begin
      failures++;
      $display("FAIL start_enemy_id got=%0d exp=%0d", enemy_cur_id, (cb + 4) % 8);
    end
    checks++;
    if (my_hp !== 8'd100 || my_cur !== 2'd0 || menu_sel !== 2'd0 || player_turn !== 1'b1) begin
      failures++;
      $display("FAIL start_player got hp=%0d cur=%0d sel=%0d turn=%0b exp 100/0/0/1",
               my_hp, my_cur, menu_sel, player_turn);
    end
  endtask

  task automatic navigate(input int mv);
    bit dir;
    if ($urandom_range(3) == 0) press(8'h04);
    dir = 1'($urandom_range(1));
    while (e_sel != mv) begin
      if (dir) begin
        press(KS);
        e_sel = (e_sel + 1) % 4;
      end else begin
        press(KW);
        e_sel = (e_sel + 3) % 4;
      end
    end
    checks++;
    if (menu_sel !== 2'(e_sel)) begin
      failures++;
      $display("FAIL nav_menu_sel got=%0d exp=%0d", menu_sel, e_sel);
    end
  endtask

  // One full player turn plus the enemy reply (or the battle end).
  task automatic take_turn(input int mv, input bit want_miss);
    logic [7:0] la, le, nx;
    int dmg, n, snap;
    navigate(mv);
    if (want_miss) begin
      n = 0;
      nx = lstep(m_lfsr);
      while (nx[1:0] != 2'd0 && n < 64) begin
        tick();
        nx = lstep(m_lfsr);
        n++;
      end
    end
    keycode = KE;
    tick();
    keycode = 8'd0;
    la = m_lfsr;
    checks++;
    if (player_turn !== 1'b0) begin
      failures++;
      $display("FAIL p_attack_turn got=%0b exp=0", player_turn);
    end
    if (mv == 3) begin
      e_hp[e_cur] = (e_hp[e_cur] + 25 > BHP) ? BHP : e_hp[e_cur] + 25;
    end else begin
      dmg = (mv == 0) ? 20 : (mv == 1) ? 30 : ((la[1:0] != 2'd0) ? 40 : 0);
      e_enemy = (e_enemy > dmg) ? e_enemy - dmg : 0;
    end
    tick();
    checks++;
    if (enemy_hp !== 8'(e_enemy) || my_hp !== 8'(e_hp[e_cur])) begin
      failures++;
      $display("FAIL after_move enemy got=%0d exp=%0d my got=%0d exp=%0d",
               enemy_hp, e_enemy, my_hp, e_hp[e_cur]);
    end
    if (e_enemy == 0) begin
      e_done = 1;
      e_won = 1;
      snap = e_hp[e_cur];
      checks++;
      if (end_battle !== 1'b1 || result !== 1'b1) begin
        failures++;
        $display("FAIL win_pulse got end=%0b res=%0b exp 1/1", end_battle, result);
      end
      tick();
      checks++;
      if (end_battle !== 1'b0) begin
        failures++;
        $display("FAIL win_pulse_width got=%0b exp=0", end_battle);
      end
      repeat (D + 2) tick();
      checks++;
      if (my_hp !== 8'(snap) || result !== 1'b1) begin
        failures++;
        $display("FAIL no_attack_after_kill hp got=%0d exp=%0d res=%0b", my_hp, snap, result);
      end
      is_battle = 1'b0;
      return;
    end
    checks++;
    if (end_battle !== 1'b0 || player_turn !== 1'b0) begin
      failures++;
      $display("FAIL e_wait got end=%0b turn=%0b exp 0/0", end_battle, player_turn);
    end
    repeat (D) tick();
    le = m_lfsr;
    tick();
    dmg = 5 + int'(le[3:0]);
    e_hp[e_cur] = (e_hp[e_cur] > dmg) ? e_hp[e_cur] - dmg : 0;
    checks++;
    if (my_hp !== 8'(e_hp[e_cur])) begin
      failures++;
      $display("FAIL enemy_hit got=%0d exp=%0d", my_hp, e_hp[e_cur]);
    end
    if (e_hp[e_cur] > 0) begin
      checks++;
      if (player_turn !== 1'b1) begin
        failures++;
        $display("FAIL back_to_menu got=%0b exp=1", player_turn);
      end
      return;
    end
    tick();
    if (e_cur == 2) begin
      e_done = 1;
      e_won = 0;
      checks++;
      if (end_battle !== 1'b1 || result !== 1'b0) begin
        failures++;
        $display("FAIL loss_pulse got end=%0b res=%0b exp 1/0", end_battle, result);
      end
      tick();
      checks++;
      if (end_battle !== 1'b0) begin
        failures++;
        $display("FAIL loss_pulse_width got=%0b exp=0", end_battle);
      end
      is_battle = 1'b0;
    end else begin
      e_cur++;
      e_sel = 0;
      checks++;
      if (my_cur !== 2'(e_cur) || my_hp !== 8'd100 || menu_sel !== 2'd0 || player_turn !== 1'b1) begin
        failures++;
        $display("FAIL switch got cur=%0d hp=%0d sel=%0d turn=%0b exp %0d/100/0/1",
                 my_cur, my_hp, menu_sel, player_turn, e_cur);
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) tick();
    Reset = 1'b0;
    checks++;
    if (end_battle !== 1'b0 || result !== 1'b0 || my_cur !== 2'd0 || enemy_cur_id !== 3'd0 ||
        enemy_hp !== 8'd0 || menu_sel !== 2'd0 || player_turn !== 1'b0 || my_hp !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs got end=%0b res=%0b cur=%0d id=%0d ehp=%0d sel=%0d turn=%0b hp=%0d exp all 0",
               end_battle, result, my_cur, enemy_cur_id, enemy_hp, menu_sel, player_turn, my_hp);
    end
    checks++;
    if (dut.lfsr !== 8'hA5) begin
      failures++;
      $display("FAIL reset_lfsr got=%h exp=a5", dut.lfsr);
    end
  endtask

  task automatic test_menu_hold();
    keycode = KW;
    repeat (10) tick();
    keycode = 8'd0;
    tick();
    checks++;
    if (menu_sel !== 2'd3) begin
      failures++;
      $display("FAIL hold_w got=%0d exp=3", menu_sel);
    end
    press(KW);
    checks++;
    if (menu_sel !== 2'd2) begin
      failures++;
      $display("FAIL second_w got=%0d exp=2", menu_sel);
    end
    e_sel = 2;
  endtask

  task automatic test_abort();
    bit saw_pulse;
    keycode = KE;
    tick();
    keycode = 8'd0;
    tick();
    checks++;
    if (player_turn !== 1'b0) begin
      failures++;
      $display("FAIL abort_in_wait got turn=%0b exp=0", player_turn);
    end
    is_battle = 1'b0;
    saw_pulse = 1'b0;
    repeat (D + 4) begin
      tick();
      if (end_battle !== 1'b0) saw_pulse = 1'b1;
    end
    checks++;
    if (saw_pulse || player_turn !== 1'b0) begin
      failures++;
      $display("FAIL abort got pulse=%0b turn=%0b exp 0/0", saw_pulse, player_turn);
    end
    start_battle(2);
  endtask

  task automatic test_kill();
    start_battle(0);
    for (int i = 0; i < 5; i++) begin
      take_turn(0, 1'b0);
      checks++;
      if (enemy_hp !== 8'(80 - 20 * i)) begin
        failures++;
        $display("FAIL kill_step%0d got=%0d exp=%0d", i, enemy_hp, 80 - 20 * i);
      end
    end
  endtask

  task automatic test_loss();
    start_battle(7);
    for (int t = 0; t < 90 && !e_done; t++) take_turn(2, 1'b1);
    checks++;
    if (my_cur !== 2'd2 || result !== 1'b0 || enemy_hp !== 8'd240) begin
      failures++;
      $display("FAIL loss_final got cur=%0d res=%0b ehp=%0d exp 2/0/240", my_cur, result, enemy_hp);
    end
  endtask

  task automatic test_random();
    int mv;
    for (int b = 0; b < 4; b++) begin
      start_battle(int'($urandom_range(7)));
      for (int t = 0; t < 100 && !e_done; t++) begin
        mv = int'($urandom_range(3));
        take_turn(mv, 1'b0);
      end
      checks++;
      if (result !== 1'(e_won)) begin
        failures++;
        $display("FAIL random_result got=%0b exp=%0b", result, e_won);
      end
    end
  endtask

  task automatic test_reset_mid();
    start_battle(1);
    keycode = KE;
    tick();
    keycode = 8'd0;
    Reset = 1'b1;
    tick();
    checks++;
    if (end_battle !== 1'b0 || result !== 1'b0 || my_cur !== 2'd0 || enemy_cur_id !== 3'd0 ||
        enemy_hp !== 8'd0 || menu_sel !== 2'd0 || player_turn !== 1'b0 || my_hp !== 8'd0) begin
      failures++;
      $display("FAIL midreset_outputs got end=%0b res=%0b cur=%0d id=%0d ehp=%0d sel=%0d turn=%0b hp=%0d exp all 0",
               end_battle, result, my_cur, enemy_cur_id, enemy_hp, menu_sel, player_turn, my_hp);
    end
    checks++;
    if (dut.lfsr !== 8'hA5) begin
      failures++;
      $display("FAIL midreset_lfsr got=%h exp=a5", dut.lfsr);
    end
    Reset = 1'b0;
    repeat (4) tick();
    checks++;
    if (player_turn !== 1'b0 || enemy_hp !== 8'd0) begin
      failures++;
      $display("FAIL no_restart_without_rise got turn=%0b ehp=%0d exp 0/0", player_turn, enemy_hp);
    end
    is_battle = 1'b0;
    tick();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    start_battle(2);
    test_menu_hold();
    test_abort();
    test_kill();
    test_loss();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
